riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Load/store unit between the single-cycle RV32 core's data-memory port and a req/gnt/rvalid data bus.
//  - Turns each core memory access into one bus transaction.
//  - Generates byte strobes, aligns store data, and sign/zero-extends load data.
//  - Raises stall_o so the core holds its PC and register write until the access completes.
//  - Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT  256  cycles allowed in REQ+RSP before abort with err_o; 0 disables the timeout
//  AW       32   address width
// PORTS
//  clk          in   1   core clock; sole clock domain
//  rst          in   1   synchronous, active-high reset
//  req_valid_i  in   1   core issues a load/store this cycle (MemtoReg|MemWr)
//  req_we_i     in   1   1=store, 0=load
//  req_op_i     in   3   `MemOpBus: LB=000 LH=001 LW=010 LBU=100 LHU=101 (stores use 000/001/010)
//  req_addr_i   in   AW  byte address (ALU result)
//  req_wdata_i  in   32  store data (rs2 value)
//  stall_o      out  1   hold PC/regfile write-back
//  rdata_o      out  32  extended load result; valid in DONE
//  misalign_o   out  1   one-cycle pulse: misaligned access rejected
//  err_o        out  1   one-cycle pulse in DONE: access aborted by timeout
//  mem_req_o    out  1   bus request
//  mem_we_o     out  1   bus write
//  mem_addr_o   out  AW  word-aligned address {addr[AW-1:2],2'b00}
//  mem_be_o     out  4   byte enables
//  mem_wdata_o  out  32  lane-replicated store data
//  mem_gnt_i    in   1   bus accepted request
//  mem_rvalid_i in   1   response/ack (loads and stores)
//  mem_rdata_i  in   32  raw read word
// BEHAVIOUR
//  Reset values: state IDLE; all outputs 0; timeout counter 0.
//  States:
//  - IDLE:
//    - req_valid_i & aligned: latch we/op/addr/wdata, stall_o=1 (combinational), go REQ.
//    - req_valid_i & misaligned: misalign_o=1, stall_o=0, no bus activity, stay IDLE.
//      Misaligned = LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0.
//  - REQ:
//    - mem_req_o=1 with registered we/addr/be/wdata; stall_o=1.
//    - Request fields stay stable until mem_gnt_i.
//    - gnt -> RSP. mem_rvalid_i is ignored in REQ.
//  - RSP:
//    - mem_req_o=0, stall_o=1.
//    - On rvalid: capture the extended rdata (loads only) -> DONE.
//  - DONE:
//    - stall_o=0, rdata_o holds the result, core commits this cycle -> IDLE.
//    - req_valid_i in DONE belongs to the same instruction and is ignored.
//  Latency: bus with gnt and rvalid on first opportunity gives 3 stall cycles; DONE in the 4th cycle.
//  Lanes:
//  - Byte: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
//  - Half: be=addr[1]?4'b1100:4'b0011; wdata={2{wdata[15:0]}}.
//  - Word: be=4'b1111.
//  - Loads select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  Timeout:
//  - Counter clears on leaving IDLE and increments each cycle in REQ/RSP.
//  - At count==TIMEOUT-1 without the awaited gnt/rvalid: go DONE with rdata_o=0, err_o=1.
//  - gnt/rvalid in the expiry cycle wins (normal completion, no err).
//  rdata_o keeps its last value outside DONE. Stores leave rdata_o unchanged.
//  Reset mid-transaction: next cycle IDLE, mem_req_o=0; a late rvalid is ignored.
//  Unknown req_op_i encodings are treated as word.
// STRUCTURE
//  - riscv_define.v: `MemOpBus and MemOp encodings, LSU state encodings (`LSU_IDLE..`LSU_DONE, 2 bits).
//  - One sub-module, riscv_lsu_align (combinational):
//    - misalign check, be/wdata generation, load-lane extraction and extension.
//    - used by both the request and response paths.
//  - FSM, request registers and timeout counter live in riscv_lsu.
// TESTING
//  1. LB addr=0x...03, rdata=0x80_11_22_33, gnt+rvalid immediate -> be=4'b1000, rdata_o=0xFFFF_FF80, stall 3 cycles.
//  2. SH addr=0x...02, wdata=0x0000_ABCD -> mem_we_o=1, be=4'b1100, mem_wdata_o=0xABCD_ABCD; no rdata_o change.
//  3. LW addr=0x...01 -> misalign_o=1 same cycle, stall_o=0, mem_req_o never asserted.
//  4. gnt held low 5 cycles, then rvalid 3 cycles after gnt, LHU rdata 0x0000_F00D addr[1]=0 -> request fields stable throughout; rdata_o=0x0000_F00D.
//  5. TIMEOUT=8, no rvalid -> DONE after 8 cycles in REQ/RSP, err_o pulse, rdata_o=0; rvalid in expiry cycle -> no err.
//  6. rst asserted in RSP, then rvalid -> IDLE, mem_req_o=0, stall_o=0, rdata_o stays 0.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, memory-op encodings, access size.
// Pure declarations; no latency.
// No flow control of its own.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  // Core memory-op bus encodings (stores use the signed byte/half/word codes)
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Anything that is not a byte or half encoding is handled as a word access
  function automatic acc_size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU: op_size = SZ_BYTE;
      OP_LH, OP_LHU: op_size = SZ_HALF;
      default:       op_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane logic: misalign check, byte enables, store replication, load extraction/extension.
// Purely combinational, zero latency.
// No flow control; request side and response side are independent.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  rsp_op,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Request side: alignment check, strobes and lane-replicated store data
  always_comb begin
    misalign = 1'b0;
    be       = 4'b1111;
    wdata    = req_wdata;
    case (op_size(req_op))
      SZ_BYTE: begin
        be    = 4'b0001 << req_off;
        wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        misalign = req_off[0];
        be       = req_off[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{req_wdata[15:0]}};
      end
      default: begin
        misalign = |req_off;
      end
    endcase
  end

  // Response side: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    byte_lane = rsp_rdata[{rsp_off, 3'b000} +: 8];
    half_lane = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    rdata     = rsp_rdata;
    case (op_size(rsp_op))
      SZ_BYTE: rdata = rsp_op[2] ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: rdata = rsp_op[2] ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: rdata = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one req/gnt/rvalid bus transaction per core memory access.
// Latency: 3 stall cycles with immediate gnt and rvalid; result committed in the 4th (DONE).
// Backpressure: stall_o holds the core while waiting for gnt/rvalid; timeout aborts with err_o.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic          req_we_i,
  input  logic [2:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          stall_o,
  output logic [31:0]   rdata_o,
  output logic          misalign_o,
  output logic          err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    state, state_nxt;
  logic          we_q;
  logic [2:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic          misalign;
  logic [3:0]    be_a;
  logic [31:0]   wdata_a;
  logic [31:0]   rdata_a;
  logic          accept;
  logic          expire;
  logic          timeout_hit;

  riscv_lsu_align u_align (
    .req_op    (req_op_i),
    .req_off   (req_addr_i[1:0]),
    .req_wdata (req_wdata_i),
    .misalign  (misalign),
    .be        (be_a),
    .wdata     (wdata_a),
    .rsp_op    (op_q),
    .rsp_off   (addr_q[1:0]),
    .rsp_rdata (mem_rdata_i),
    .rdata     (rdata_a)
  );

  assign accept = (state == LSU_IDLE) && req_valid_i && !misalign;
  assign expire = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Next-state and per-state handshake outputs
  always_comb begin
    state_nxt   = state;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    misalign_o  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (req_valid_i) begin
          if (misalign) begin
            misalign_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            state_nxt = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_gnt_i) begin
          state_nxt = LSU_RSP;
        end else if (expire) begin
          state_nxt   = LSU_DONE;
          timeout_hit = 1'b1;
        end
      end
      LSU_RSP: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          state_nxt = LSU_DONE;
        end else if (expire) begin
          state_nxt   = LSU_DONE;
          timeout_hit = 1'b1;
        end
      end
      LSU_DONE: begin
        state_nxt = LSU_IDLE;
      end
      default: begin
        state_nxt = LSU_IDLE;
      end
    endcase
  end

  // State, latched request, timeout counter and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we_i;
        op_q    <= req_op_i;
        addr_q  <= req_addr_i;
        be_q    <= be_a;
        wdata_q <= wdata_a;
        err_q   <= 1'b0;
        cnt     <= '0;
      end
      if (state == LSU_REQ || state == LSU_RSP) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end
      if (state == LSU_RSP && mem_rvalid_i && !we_q) begin
        rdata_q <= rdata_a;
      end
    end
  end

  assign err_o       = (state == LSU_DONE) && err_q;
  assign rdata_o     = rdata_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[AW-1:2], 2'b00};
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized and directed checks of riscv_lsu against a byte-arithmetic reference model.
// Inputs driven 1 time unit after posedge; outputs sampled 1 unit later.
// Bus model responds with programmable gnt/rvalid delays, including timeouts.
module tb_riscv_lsu;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall_o, misalign_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rdata = 32'd0;

  riscv_lsu #(.TIMEOUT(TO), .AW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_we_i     (req_we),
    .req_op_i     (req_op),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access width in bytes
  function automatic int op_bytes(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_off(input logic [2:0] op, input logic [31:0] addr);
    int a = int'(addr % 4);
    return a - (a % op_bytes(op));
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
    int v = ((1 << op_bytes(op)) - 1) << lane_off(op, addr);
    return 4'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
    case (op_bytes(op))
      1:       return (w & 32'hFF) * 32'h0101_0101;
      2:       return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] raw);
    int          n = op_bytes(op);
    logic [31:0] v = raw >> (8 * lane_off(op, addr));
    logic [31:0] mask;
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v    = v & mask;
      if (op != 3'b100 && op != 3'b101 && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One core access; gnt_wait/rsp_wait are idle cycles before the bus responds
  task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] raw,
                            input int gnt_wait, input int rsp_wait, output int stall_cycles);
    bit          mis = (addr % op_bytes(op)) != 0;
    int          phase = 0;
    int          w = 0;
    int          t = 0;
    bit          done = 0;
    bit          to = 0;
    bit          ev;
    logic [31:0] exp;
    stall_cycles = 0;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("idle_misalign", misalign_o, mis);
    chk("idle_stall", stall_o, !mis);
    chk("idle_req", mem_req_o, 0);
    if (stall_o) stall_cycles++;
    if (mis) begin
      tick();
      req_valid = 1'b0;
      #1;
      chk("mis_no_req", mem_req_o, 0);
      chk("mis_rdata", rdata_o, last_rdata);
      tick();
      return;
    end
    tick();
    while (!done && t < 64) begin
      mem_gnt    = (phase == 0) && (w == gnt_wait);
      mem_rvalid = (phase == 1) ? (w == rsp_wait) : 1'($urandom_range(0, 1));
      mem_rdata  = (phase == 1 && mem_rvalid) ? raw : $urandom();
      #1;
      chk("busy_stall", stall_o, 1);
      chk("busy_req", mem_req_o, phase == 0);
      if (phase == 0) begin
        chk("req_we", mem_we_o, we);
        chk("req_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        chk("req_be", mem_be_o, model_be(op, addr));
        chk("req_wdata", mem_wdata_o, model_wdata(op, wdata));
      end
      if (stall_o) stall_cycles++;
      ev = (phase == 0) ? mem_gnt : mem_rvalid;
      if (ev) begin
        if (phase == 0) begin
          phase = 1;
          w = 0;
        end else begin
          done = 1;
        end
      end else if (t == TO - 1) begin
        done = 1;
        to = 1;
      end else begin
        w++;
      end
      t++;
      tick();
    end
    chk("bus_bound", done, 1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    exp = to ? 32'd0 : (we ? last_rdata : model_load(op, addr, raw));
    chk("done_stall", stall_o, 0);
    chk("done_req", mem_req_o, 0);
    chk("done_err", err_o, to);
    chk("done_rdata", rdata_o, exp);
    last_rdata = exp;
    tick();
    req_valid = 1'b0;
    #1;
    chk("after_stall", stall_o, 0);
    chk("after_err", err_o, 0);
    chk("after_rdata", rdata_o, last_rdata);
    tick();
  endtask

  initial begin
    int          sc;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [2:0]  ld_ops [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    tick();

    // Reset while waiting for rvalid, then a late rvalid
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h100;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_mid_req", mem_req_o, 0);
    chk("rst_mid_stall", stall_o, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("rst_late_rdata", rdata_o, 0);
    chk("rst_late_stall", stall_o, 0);
    tick();

    // LB at byte 3, immediate bus
    run_access(1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'h8011_2233, 0, 0, sc);
    chk("t1_stall_cycles", sc, 3);
    chk("t1_rdata", rdata_o, 32'hFFFF_FF80);
    // SH to upper half
    run_access(1'b1, 3'b001, 32'h1000_0002, 32'h0000_ABCD, 32'h0, 0, 0, sc);
    chk("t2_rdata_kept", rdata_o, 32'hFFFF_FF80);
    // Misaligned LW
    run_access(1'b0, 3'b010, 32'h1000_0001, 32'h0, 32'h0, 0, 0, sc);
    // Slow grant and slow response
    run_access(1'b0, 3'b101, 32'h2000_0000, 32'h0, 32'h0000_F00D, 5, 2, sc);
    chk("t4_rdata", rdata_o, 32'h0000_F00D);
    // Timeout waiting for rvalid
    run_access(1'b0, 3'b010, 32'h3000_0000, 32'h0, 32'h1234_5678, 0, 1000, sc);
    chk("t5_busy_cycles", sc - 1, TO);
    // rvalid exactly in the expiry cycle completes normally
    run_access(1'b0, 3'b010, 32'h3000_0004, 32'h0, 32'h1234_5678, 0, TO - 2, sc);
    chk("t5b_rdata", rdata_o, 32'h1234_5678);
    // Timeout waiting for gnt
    run_access(1'b0, 3'b100, 32'h3000_0001, 32'h0, 32'h0, 1000, 0, sc);

    for (int i = 0; i < 300; i++) begin
      int gw = $urandom_range(0, 3);
      int rw = $urandom_range(0, 3);
      we   = 1'($urandom_range(0, 1));
      op   = we ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 7)];
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(op_bytes(op) - 1);
      if (!we && $urandom_range(0, 9) == 0) rw = $urandom_range(6, 14);
      run_access(we, op, addr, $urandom(), $urandom(), gw, rw, sc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
